// File: rtl/mem_arb_pkg.sv
// Shared types for the cache/memory port arbiter.
// Pure declarations: no logic, no latency.
// Not applicable: nothing here carries flow control.
package mem_arb_pkg;

  // Words per cache block (16-byte block of 16-bit words).
  localparam int BEATS_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_I_FILL  = 2'd1,
    ST_D_FILL  = 2'd2,
    ST_D_WRITE = 2'd3
  } arb_state_t;

  // Identifies which cache won the most recent grant.
  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

endpackage

// File: rtl/cache_mem_arbiter_beat_counter.sv
// Counts returned read beats of one cache-block fill.
// Latency: count updates on the edge after an increment; last_beat is combinational.
// No backpressure: increments are accepted every cycle they are presented.
module beat_counter #(
  parameter int BEATS = 8,
  parameter int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count,
  output logic             o_last_beat
);

  logic [CNT_W-1:0] r_count;

  assign o_count     = r_count;
  assign o_last_beat = i_inc && (r_count == CNT_W'(BEATS - 1));

  // Beat count: clears on request, wraps to zero on the final beat of a block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= o_last_beat ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Grants the single memory port to the I-cache or D-cache and routes read valids to the owner.
// Latency: grant one cycle after request in IDLE; address/enable/valid routing is combinational.
// Non-owner requests simply wait; a fill grant is held until all beats have returned.
module cache_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BEATS  = BEATS_DEF,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_grant,
  output logic              i_data_valid,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_grant,
  output logic              d_data_valid,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_data_valid
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  arb_state_t       r_state;
  arb_state_t       w_next_state;
  req_id_t          r_last_win;
  req_id_t          w_next_last_win;
  logic             w_fill;
  logic             w_inc;
  logic             w_clear;
  logic             w_last_beat;
  logic [CNT_W-1:0] w_count;

  // Valids only count while a fill owns the port; stray valids elsewhere are dropped.
  assign w_fill  = (r_state == ST_I_FILL) || (r_state == ST_D_FILL);
  assign w_inc   = mem_data_valid && w_fill;
  // A stale count (e.g. from an abandoned fill) is wiped while idle.
  assign w_clear = (r_state == ST_IDLE) && (w_count != '0);

  beat_counter #(
    .BEATS (BEATS),
    .CNT_W (CNT_W)
  ) u_beat_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_clear),
    .i_inc       (w_inc),
    .o_count     (w_count),
    .o_last_beat (w_last_beat)
  );

  // State and last-winner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_last_win <= REQ_I;
    end else begin
      r_state    <= w_next_state;
      r_last_win <= w_next_last_win;
    end
  end

  // Next state: arbitrate from IDLE only, so every grant is followed by an IDLE cycle.
  always_comb begin
    w_next_state    = r_state;
    w_next_last_win = r_last_win;
    case (r_state)
      ST_IDLE: begin
        if (i_req && (!d_req || (r_last_win == REQ_D))) begin
          w_next_state    = ST_I_FILL;
          w_next_last_win = REQ_I;
        end else if (d_req) begin
          w_next_state    = d_wr ? ST_D_WRITE : ST_D_FILL;
          w_next_last_win = REQ_D;
        end
      end
      ST_I_FILL, ST_D_FILL: begin
        if (w_last_beat) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_D_WRITE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Output decode: grants are state decodes, memory controls muxed from the owner.
  always_comb begin
    i_grant      = 1'b0;
    d_grant      = 1'b0;
    i_data_valid = 1'b0;
    d_data_valid = 1'b0;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    case (r_state)
      ST_I_FILL: begin
        i_grant      = 1'b1;
        i_data_valid = mem_data_valid;
        mem_enable   = i_req;
        mem_addr     = i_addr;
      end
      ST_D_FILL: begin
        d_grant      = 1'b1;
        d_data_valid = mem_data_valid;
        mem_enable   = d_req;
        mem_addr     = d_addr;
      end
      ST_D_WRITE: begin
        d_grant    = 1'b1;
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = d_addr;
      end
      default: begin
      end
    endcase
  end

  assign mem_wdata = d_wdata;

endmodule
